des_round_ctrl: RTL and testbench
=================================

DES_ROUND_CTRL -- requirements
Module: des_round_ctrl

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 16, number of Feistel round cycles sequenced per block.
REQ-002 SHALL have parameter IDX_W, default 4, width of round/subkey index outputs.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  requester offers a block.
REQ-006 SHALL have port in_ready  output  1  controller accepts a block this cycle.
REQ-007 SHALL have port in_mode  input  1  0 = encrypt, 1 = decrypt.
REQ-008 SHALL have port in_text  input  64  plaintext or ciphertext.
REQ-009 SHALL have port in_key  input  64  DES key.
REQ-010 SHALL have port load  output  1  one-cycle pulse; datapath captures text_q/key_q.
REQ-011 SHALL have port round_en  output  1  datapath advances one round.
REQ-012 SHALL have port round_idx  output  IDX_W  current round number, 0..NUM_ROUNDS-1.
REQ-013 SHALL have port key_idx  output  IDX_W  subkey index for key schedule.
REQ-014 SHALL have port mode  output  1  latched in_mode, drives datapath select.
REQ-015 SHALL have ports text_q, key_q  output  64 each  operands latched at accept.
REQ-016 SHALL have port dp_result  input  64  datapath output after final permutation.
REQ-017 SHALL have port out_valid  output  1  result available.
REQ-018 SHALL have port out_ready  input  1  consumer takes result.
REQ-019 SHALL have port out_text  output  64  captured result.
REQ-020 SHALL have port blk_cnt  output  16  completed-block count (see Configuration).

Function
REQ-021 SHALL implement FSM states IDLE, LOAD, ROUND, OUT.
REQ-022 SHALL assert in_ready only in IDLE; accept = in_valid & in_ready; on accept, latch in_mode/in_text/in_key into mode/text_q/key_q and go to LOAD.
REQ-023 SHALL assert load for exactly the one cycle spent in LOAD, then enter ROUND with round counter 0.
REQ-024 SHALL, in ROUND, assert round_en every cycle, increment round_idx each cycle, and on round_idx = NUM_ROUNDS-1 capture dp_result into out_text and enter OUT.
REQ-025 SHALL drive key_idx = round_idx when mode=0 and NUM_ROUNDS-1-round_idx when mode=1; key_idx = 0 outside ROUND.
REQ-026 SHALL hold out_valid high and out_text stable in OUT until out_valid & out_ready, then return to IDLE next cycle.
REQ-027 SHALL give latency: accept at edge of cycle T -> load in T+1 -> round_en in T+2..T+NUM_ROUNDS+1 -> out_valid first high in T+NUM_ROUNDS+2 (T+18 at default).
REQ-028 SHALL ignore in_valid and all in_* changes outside IDLE; latched operands are not altered mid-block.
REQ-029 SHALL not accept a new block in the cycle out_valid & out_ready completes; minimum spacing is NUM_ROUNDS+3 cycles.
REQ-030 SHALL keep round_en, load low outside ROUND/LOAD respectively; round_idx holds 0 outside ROUND.

Reset
REQ-031 SHALL, on rst low at any time including mid-block, go to IDLE immediately; in_ready=1 once rst high, all other outputs 0, operand/result registers 0, blk_cnt 0.
REQ-032 SHALL resume normal operation on the first rising clk edge after rst deasserts; any in-flight block is discarded without out_valid.

Configuration
REQ-033 SHALL, with DES_ROUND_CTRL_BLKCNT_EN defined, increment blk_cnt by 1 on each out_valid & out_ready, wrapping 16'hFFFF -> 0.
REQ-034 SHALL, without DES_ROUND_CTRL_BLKCNT_EN, tie blk_cnt to 0 and instantiate no counter register.

Verification
REQ-035 Encrypt: key 133457799BBCDFF1, text 0123456789ABCDEF, reference datapath -> out_text 85E813540F0AB405 at T+18, key_idx 0..15.
REQ-036 Decrypt: same key, text 85E813540F0AB405, mode=1 -> out_text 0123456789ABCDEF, key_idx 15..0.
REQ-037 Backpressure: out_ready low 10 cycles after out_valid -> out_valid/out_text held, in_ready 0, no new accept.
REQ-038 Reset at round_idx=7 -> all outputs 0 asynchronously, in_ready 1 after release, no out_valid for aborted block.
REQ-039 in_valid held high continuously with changing in_text -> only IDLE-cycle values accepted; blocks spaced 19 cycles with out_ready=1.
REQ-040 With DES_ROUND_CTRL_BLKCNT_EN, 65537 completed blocks (counter preloaded via force) -> blk_cnt wraps to 1; without macro blk_cnt stays 0.

Source files
------------

// File: rtl/des_round_ctrl.sv
// Round sequencer for an iterative DES datapath: accepts a block, pulses load, steps rounds, holds the result.
// Optional completed-block counter enabled by defining DES_ROUND_CTRL_BLKCNT_EN.
module des_round_ctrl #(
    parameter int unsigned NUM_ROUNDS = 16,
    parameter int unsigned IDX_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [63:0]      in_text,
    input  logic [63:0]      in_key,
    output logic             load,
    output logic             round_en,
    output logic [IDX_W-1:0] round_idx,
    output logic [IDX_W-1:0] key_idx,
    output logic             mode,
    output logic [63:0]      text_q,
    output logic [63:0]      key_q,
    input  logic [63:0]      dp_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_text,
    output logic [15:0]      blk_cnt
);

    localparam int unsigned    DW        = 64;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, ROUND, OUT} state_t;

    state_t           state, state_nxt;
    logic             in_ready_nxt, load_nxt, round_en_nxt, out_valid_nxt, mode_nxt;
    logic [IDX_W-1:0] round_idx_nxt, key_idx_nxt;
    logic [DW-1:0]    text_nxt, key_nxt, out_text_nxt;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            load      <= 1'b0;
            round_en  <= 1'b0;
            round_idx <= '0;
            key_idx   <= '0;
            mode      <= 1'b0;
            text_q    <= '0;
            key_q     <= '0;
            out_valid <= 1'b0;
            out_text  <= '0;
        end else begin
            state     <= state_nxt;
            in_ready  <= in_ready_nxt;
            load      <= load_nxt;
            round_en  <= round_en_nxt;
            round_idx <= round_idx_nxt;
            key_idx   <= key_idx_nxt;
            mode      <= mode_nxt;
            text_q    <= text_nxt;
            key_q     <= key_nxt;
            out_valid <= out_valid_nxt;
            out_text  <= out_text_nxt;
        end
    end

    // Next state and next output values
    always_comb begin
        state_nxt     = state;
        in_ready_nxt  = 1'b0;
        load_nxt      = 1'b0;
        round_en_nxt  = 1'b0;
        round_idx_nxt = '0;
        key_idx_nxt   = '0;
        mode_nxt      = mode;
        text_nxt      = text_q;
        key_nxt       = key_q;
        out_valid_nxt = 1'b0;
        out_text_nxt  = out_text;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    state_nxt = LOAD;
                    load_nxt  = 1'b1;
                    mode_nxt  = in_mode;
                    text_nxt  = in_text;
                    key_nxt   = in_key;
                end else begin
                    in_ready_nxt = 1'b1;
                end
            end
            LOAD: begin
                state_nxt    = ROUND;
                round_en_nxt = 1'b1;
                key_idx_nxt  = mode ? LAST_IDX : '0;
            end
            ROUND: begin
                if (round_idx == LAST_IDX) begin
                    state_nxt     = OUT;
                    out_valid_nxt = 1'b1;
                    out_text_nxt  = dp_result;
                end else begin
                    round_en_nxt  = 1'b1;
                    round_idx_nxt = round_idx + IDX_W'(1);
                    // Decrypt walks the key schedule backwards
                    key_idx_nxt   = mode ? (LAST_IDX - round_idx_nxt) : round_idx_nxt;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_nxt    = IDLE;
                    in_ready_nxt = 1'b1;
                end else begin
                    out_valid_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt    = IDLE;
                in_ready_nxt = 1'b1;
            end
        endcase
    end

`ifdef DES_ROUND_CTRL_BLKCNT_EN
    // Completed-block counter, wraps naturally at 16 bits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blk_cnt <= '0;
        end else if (out_valid && out_ready) begin
            blk_cnt <= blk_cnt + 16'd1;
        end
    end
`else
    assign blk_cnt = '0;
`endif

endmodule

// File: tb/tb_des_round_ctrl.sv
// Bench for des_round_ctrl: cycle-count reference model, known-answer vectors, corner sequences, random traffic.
module tb_des_round_ctrl;

    localparam int N  = 16;
    localparam int IW = 4;
    localparam logic [63:0] DKEY = 64'h133457799BBCDFF1;
    localparam logic [63:0] PTXT = 64'h0123456789ABCDEF;
    localparam logic [63:0] CTXT = 64'h85E813540F0AB405;

    logic          clk, rst;
    logic          in_valid, in_ready, in_mode;
    logic [63:0]   in_text, in_key;
    logic          load, round_en, mode, out_valid, out_ready;
    logic [IW-1:0] round_idx, key_idx;
    logic [63:0]   text_q, key_q, dp_result, out_text;
    logic [15:0]   blk_cnt;

    int total = 0;
    int bad   = 0;

    // Model: block progress expressed as cycles elapsed since the accept edge
    bit          m_busy;
    int          m_t;
    logic        m_mode;
    logic [63:0] m_text, m_key, m_res;
`ifdef DES_ROUND_CTRL_BLKCNT_EN
    logic [15:0] m_cnt;
`endif

    typedef struct {
        logic        mode;
        logic [63:0] text;
        logic [63:0] key;
        logic [63:0] exp_out;
        int          exp_k0;
    } vec_t;

    vec_t vecs[4];

    des_round_ctrl #(.NUM_ROUNDS(N), .IDX_W(IW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_text(in_text), .in_key(in_key),
        .load(load), .round_en(round_en), .round_idx(round_idx), .key_idx(key_idx),
        .mode(mode), .text_q(text_q), .key_q(key_q), .dp_result(dp_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_text(out_text),
        .blk_cnt(blk_cnt)
    );

    // Stand-in datapath: DES known answers for the reference vectors, a simple mix otherwise
    function automatic logic [63:0] ref_fn(input logic m, input logic [63:0] t, input logic [63:0] k);
        if (!m && k == DKEY && t == PTXT) return CTXT;
        if (m && k == DKEY && t == CTXT) return PTXT;
        return {t[31:0], t[63:32]} ^ k ^ {64{m}};
    endfunction

    assign dp_result = (round_en && round_idx == IW'(N - 1)) ? ref_fn(mode, text_q, key_q)
                                                             : (64'hDEAD_BEEF_0000_0000 | 64'(round_idx));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_t    = 0;
        m_mode = 1'b0;
        m_text = '0;
        m_key  = '0;
        m_res  = '0;
`ifdef DES_ROUND_CTRL_BLKCNT_EN
        m_cnt  = '0;
`endif
    endtask

    task automatic model_edge();
        if (!m_busy) begin
            if (in_valid) begin
                m_busy = 1'b1;
                m_t    = 1;
                m_mode = in_mode;
                m_text = in_text;
                m_key  = in_key;
            end
        end else if (m_t >= N + 2) begin
            if (out_ready) begin
                m_busy = 1'b0;
                m_t    = 0;
`ifdef DES_ROUND_CTRL_BLKCNT_EN
                m_cnt  = m_cnt + 16'd1;
`endif
            end
        end else begin
            if (m_t == N + 1) m_res = ref_fn(m_mode, m_text, m_key);
            m_t++;
        end
    endtask

    task automatic check_outputs();
        bit ren;
        int ri, ki;
        logic [15:0] cnt_exp;
        ren = m_busy && m_t >= 2 && m_t <= N + 1;
        ri  = ren ? m_t - 2 : 0;
        ki  = ren ? (m_mode ? N - 1 - ri : ri) : 0;
`ifdef DES_ROUND_CTRL_BLKCNT_EN
        cnt_exp = m_cnt;
`else
        cnt_exp = 16'd0;
`endif
        check("ctrl", 64'({in_ready, load, round_en, out_valid, mode}),
              64'({!m_busy, m_busy && m_t == 1, ren, m_busy && m_t >= N + 2, m_mode}));
        check("idx", 64'({round_idx, key_idx}), 64'({IW'(ri), IW'(ki)}));
        check("text_q", text_q, m_text);
        check("key_q", key_q, m_key);
        check("out_text", out_text, m_res);
        check("blk_cnt", 64'(blk_cnt), 64'(cnt_exp));
    endtask

    // One cycle: compare on the falling edge, advance the model on the rising edge
    task automatic tick();
        @(negedge clk);
        if (!rst) model_reset();
        check_outputs();
        @(posedge clk);
        if (!rst) model_reset();
        else model_edge();
        #1;
    endtask

    task automatic run_block(input logic m, input logic [63:0] t, input logic [63:0] k);
        int guard;
        in_valid = 1'b1; in_mode = m; in_text = t; in_key = k; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 40) begin
            tick();
            guard++;
        end
        check("blk_done", 64'(out_valid), 64'(1));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        int lat, k0, guard, seen, nloads;
        int load_cyc[$];
        vecs[0] = '{1'b0, PTXT, DKEY, CTXT, 0};
        vecs[1] = '{1'b1, CTXT, DKEY, PTXT, N - 1};
        vecs[2] = '{1'b0, 64'hFFFF_FFFF_0000_0000, 64'h0, 64'h0000_0000_FFFF_FFFF, 0};
        vecs[3] = '{1'b1, 64'h0, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, N - 1};

        rst = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_text = '0; in_key = '0; out_ready = 1'b0;
        model_reset();
        tick(); tick();
        rst = 1'b1;
        tick();
        check("rst_outs", 64'({in_ready, load, round_en, out_valid, mode, round_idx, key_idx}),
              64'({1'b1, 4'b0, IW'(0), IW'(0)}));
        check("rst_regs", text_q | key_q | out_text, 64'h0);

        // Known-answer vectors: latency, first subkey index, result
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_mode = vecs[i].mode; in_text = vecs[i].text; in_key = vecs[i].key;
            out_ready = 1'b0;
            tick();
            in_valid = 1'b0; in_text = 64'hA5A5_A5A5_0000_0000 ^ 64'(i); in_key = ~in_key;
            lat = 1; k0 = -1;
            while (!out_valid && lat < 40) begin
                if (round_en && k0 < 0) k0 = int'(key_idx);
                tick();
                lat++;
            end
            check("latency", 64'(lat), 64'(N + 2));
            check("kidx_first", 64'(k0), 64'(vecs[i].exp_k0));
            check("vec_out", out_text, vecs[i].exp_out);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end

        // Backpressure: result held while consumer stalls, no new accept
        in_valid = 1'b1; in_mode = 1'b0; in_text = PTXT; in_key = DKEY;
        tick();
        guard = 0;
        while (!out_valid && guard < 40) begin
            in_text = {$urandom, $urandom};
            tick();
            guard++;
        end
        for (int i = 0; i < 10; i++) begin
            in_text = {$urandom, $urandom};
            tick();
        end
        check("bp_hold", 64'({out_valid, in_ready, load}), 64'({1'b1, 1'b0, 1'b0}));
        check("bp_text", out_text, CTXT);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release", 64'({in_ready, out_valid}), 64'({1'b1, 1'b0}));

        // Asynchronous reset in the middle of a block
        in_valid = 1'b1; in_mode = 1'b1; in_text = CTXT; in_key = DKEY;
        tick();
        in_valid = 1'b0;
        guard = 0;
        while (!(round_en && round_idx == IW'(7)) && guard < 30) begin
            tick();
            guard++;
        end
        check("arst_reach", 64'(round_idx), 64'(7));
        rst = 1'b0;
        #1;
        check("arst_ctrl", 64'({load, round_en, out_valid, mode, round_idx, key_idx}), 64'(0));
        check("arst_regs", text_q | key_q | out_text, 64'h0);
        tick();
        rst = 1'b1;
        tick();
        check("arst_ready", 64'(in_ready), 64'(1));
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("arst_no_out", 64'(seen), 64'(0));

        // in_valid held high with changing text: accepts spaced NUM_ROUNDS+3 apart
        in_valid = 1'b1; out_ready = 1'b1; in_key = DKEY;
        for (int c = 0; c < 60; c++) begin
            in_text = {$urandom, $urandom};
            in_mode = 1'($urandom_range(0, 1));
            tick();
            if (load) load_cyc.push_back(c);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        nloads = load_cyc.size();
        check("sp_count", 64'(nloads), 64'(4));
        for (int i = 1; i < nloads; i++)
            check("sp_gap", 64'(load_cyc[i] - load_cyc[i-1]), 64'(N + 3));
        for (int i = 0; i < 20; i++) tick();

`ifdef DES_ROUND_CTRL_BLKCNT_EN
        // Counter wrap: preload to all ones, two more blocks land on 1
        force dut.blk_cnt = 16'hFFFF;
        #1;
        release dut.blk_cnt;
        m_cnt = 16'hFFFF;
        run_block(1'b0, PTXT, DKEY);
        run_block(1'b1, CTXT, DKEY);
        check("cnt_wrap", 64'(blk_cnt), 64'(1));
`else
        run_block(1'b0, PTXT, DKEY);
        check("cnt_tied", 64'(blk_cnt), 64'(0));
`endif

        // Random traffic with stalls and occasional resets
        for (int c = 0; c < 2500; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_mode   = 1'($urandom_range(0, 1));
            in_text   = {$urandom, $urandom};
            in_key    = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 399) != 0);
            tick();
        end
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 25; i++) tick();
        check("final_idle", 64'(in_ready), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
